// File: rtl/game_table_lcd_scan_pkg.sv
// Shared constants, state encoding and the pixel-row stepping helper for the
// game-table LCD scanner.
package game_table_lcd_scan_pkg;

  localparam int GRID_W    = 10;
  localparam int GRID_H    = 10;
  localparam int LCD_PAGES = 8;

  localparam logic [7:0] LCD_CMD_PAGE = 8'hB8;
  localparam logic [7:0] LCD_CMD_COL  = 8'h40;

  typedef enum logic [2:0] {
    SCAN_IDLE     = 3'd0,
    SCAN_SNAP     = 3'd1,
    SCAN_PAGE_CMD = 3'd2,
    SCAN_COL_CMD  = 3'd3,
    SCAN_DATA     = 3'd4,
    SCAN_DONE     = 3'd5
  } scan_state_t;

  // Vertical pixel position expressed as (cell row, pixel within cell).
  typedef struct packed {
    logic [6:0] row;
    logic [2:0] sub;
  } ypos_t;

  // Advance a vertical position by one pixel row without a divider.
  function automatic ypos_t step_y(input ypos_t p, input logic [2:0] sub_max);
    ypos_t r;
    if (p.sub == sub_max) begin
      r.row = p.row + 7'd1;
      r.sub = 3'd0;
    end else begin
      r.row = p.row;
      r.sub = p.sub + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_table_lcd_scan_lcd_byte_gen.sv
// Builds one 8-pixel-tall LCD column byte from the frozen game table.
// Pixel rows are walked by an unrolled 8-step increment from the page's
// starting (row, sub) pair, so no division is needed.
module lcd_byte_gen
  import game_table_lcd_scan_pkg::*;
#(
  parameter int CELL_PX = 6,
  parameter int GAP     = 0
) (
  input  logic [99:0] i_snapshot,
  input  logic [3:0]  i_cell_col,
  input  logic [2:0]  i_x_sub,
  input  logic [6:0]  i_row_base,
  input  logic [2:0]  i_y_sub_base,
  output logic [7:0]  o_col_byte
);

  localparam logic [2:0] SUB_MAX = 3'(CELL_PX - 1);

  // Evaluate the pixel rule for the 8 rows covered by this byte (bit0 = top).
  always_comb begin
    ypos_t      p;
    logic [6:0] idx;
    logic       lit;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    o_col_byte = '0;
    p          = '{row: i_row_base, sub: i_y_sub_base};
    for (int b = 0; b < 8; b++) begin
      lit = 1'b0;
      idx = '0;
      // Rows below the play field never index the table.
      if (p.row < 7'(GRID_H)) begin
        idx = p.row * 7'(GRID_W) + {3'b000, i_cell_col};
        lit = i_snapshot[idx];
      end
      if ((GAP != 0) && ((i_x_sub == SUB_MAX) || (p.sub == SUB_MAX))) begin
        lit = 1'b0;
      end
      o_col_byte[b] = lit;
      p = step_y(p, SUB_MAX);
    end
  end

endmodule

// File: rtl/game_table_lcd_scan.sv
// Snapshots the 10x10 game table on request and streams it to a KS0108-style
// LCD driver: per page a page-address command, a column-address command and
// one data byte per pixel column of the play field, with valid/ready handshake.
module game_table_lcd_scan
  import game_table_lcd_scan_pkg::*;
#(
  parameter int CELL_PX = 6,
  parameter int X_OFF   = 2,
  parameter int GAP     = 0
) (
  input  logic        clk_40M,
  input  logic        rst,
  input  logic [99:0] game_table_in,
  input  logic        frame_req,
  input  logic        lcd_ready,
  output logic        lcd_valid,
  output logic        lcd_cmd,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [2:0] SUB_MAX = 3'(CELL_PX - 1);
  localparam logic [7:0] COL_CMD = LCD_CMD_COL | 8'(X_OFF);

  scan_state_t r_state;
  scan_state_t w_next_state;
  logic [99:0] r_snapshot;
  logic        r_pending;
  logic [2:0]  r_page;
  logic [3:0]  r_cell_col;
  logic [2:0]  r_x_sub;
  ypos_t       r_pos;
  ypos_t       w_next_pos;
  logic [7:0]  w_col_byte;
  logic        w_accept;
  logic        w_last_col;
  logic        w_start;

  assign w_accept   = lcd_valid && lcd_ready;
  assign w_last_col = (r_cell_col == 4'(GRID_W - 1)) && (r_x_sub == SUB_MAX);
  assign w_start    = (r_state == SCAN_IDLE) && (frame_req || r_pending);

  lcd_byte_gen #(
    .CELL_PX (CELL_PX),
    .GAP     (GAP)
  ) u_byte_gen (
    .i_snapshot   (r_snapshot),
    .i_cell_col   (r_cell_col),
    .i_x_sub      (r_x_sub),
    .i_row_base   (r_pos.row),
    .i_y_sub_base (r_pos.sub),
    .o_col_byte   (w_col_byte)
  );

  // Starting pixel row of the next page: current start advanced by 8 rows.
  always_comb begin
    w_next_pos = r_pos;
    for (int s = 0; s < 8; s++) begin
      w_next_pos = step_y(w_next_pos, SUB_MAX);
    end
  end

  // State register.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      r_state <= SCAN_IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; outputs are held while a byte is stalled
  // because they depend only on registers that change on acceptance.
  always_comb begin
    w_next_state = r_state;
    lcd_valid    = 1'b0;
    lcd_cmd      = 1'b0;
    lcd_data     = 8'h00;
    busy         = 1'b0;
    frame_done   = 1'b0;
    unique case (r_state)
      SCAN_IDLE: begin
        if (frame_req || r_pending) w_next_state = SCAN_SNAP;
      end
      SCAN_SNAP: begin
        busy         = 1'b1;
        w_next_state = SCAN_PAGE_CMD;
      end
      SCAN_PAGE_CMD: begin
        busy      = 1'b1;
        lcd_valid = 1'b1;
        lcd_cmd   = 1'b1;
        lcd_data  = LCD_CMD_PAGE | {5'b00000, r_page};
        if (lcd_ready) w_next_state = SCAN_COL_CMD;
      end
      SCAN_COL_CMD: begin
        busy      = 1'b1;
        lcd_valid = 1'b1;
        lcd_cmd   = 1'b1;
        lcd_data  = COL_CMD;
        if (lcd_ready) w_next_state = SCAN_DATA;
      end
      SCAN_DATA: begin
        busy      = 1'b1;
        lcd_valid = 1'b1;
        lcd_data  = w_col_byte;
        if (lcd_ready && w_last_col) begin
          w_next_state = (r_page == 3'(LCD_PAGES - 1)) ? SCAN_DONE : SCAN_PAGE_CMD;
        end
      end
      SCAN_DONE: begin
        frame_done   = 1'b1;
        w_next_state = SCAN_IDLE;
      end
      default: w_next_state = SCAN_IDLE;
    endcase
  end

  // One-deep request memory: requests seen outside IDLE collapse into one.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end else if (frame_req && (r_state != SCAN_IDLE)) begin
      r_pending <= 1'b1;
    end
  end

  // Frame snapshot; frozen from SNAP until the next frame so output never tears.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      r_snapshot <= '0;
    end else if (r_state == SCAN_SNAP) begin
      r_snapshot <= game_table_in;
    end
  end

  // Page and column counters, advanced only when a data byte is accepted.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      r_page     <= '0;
      r_cell_col <= '0;
      r_x_sub    <= '0;
      r_pos      <= '0;
    end else if (r_state == SCAN_SNAP) begin
      r_page     <= '0;
      r_cell_col <= '0;
      r_x_sub    <= '0;
      r_pos      <= '0;
    end else if ((r_state == SCAN_DATA) && w_accept) begin
      if (w_last_col) begin
        r_cell_col <= '0;
        r_x_sub    <= '0;
        r_page     <= r_page + 3'd1;
        r_pos      <= w_next_pos;
      end else if (r_x_sub == SUB_MAX) begin
        r_x_sub    <= '0;
        r_cell_col <= r_cell_col + 4'd1;
      end else begin
        r_x_sub    <= r_x_sub + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_table_lcd_scan.sv
// Self-checking bench: two scanners (solid cells and grid-gap cells) share
// stimulus; a specification-level model predicts every byte of each frame.
`timescale 1ns/100ps
module tb_game_table_lcd_scan;

  localparam int CELL_PX = 6;
  localparam int X_OFF   = 2;
  localparam int BYTES_PER_PAGE = 2 + 10 * CELL_PX;
  localparam int BYTES_PER_FRAME = 8 * BYTES_PER_PAGE;

  logic        clk_40M = 1'b0;
  logic        rst = 1'b1;
  logic [99:0] game_table_in = '0;
  logic        frame_req = 1'b0;
  logic        lcd_ready = 1'b1;
  bit          rand_en = 1'b0;

  logic [1:0]  w_valid, w_cmd, w_busy, w_done;
  logic [7:0]  w_data [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Monitor state per DUT
  int          idx [2];
  bit          in_frame [2];
  logic [99:0] msnap [2];
  int          frames [2];
  logic        pv [2], pr [2], pcmd [2];
  logic [7:0]  pdata [2];

  always #12.5 clk_40M = ~clk_40M;

  game_table_lcd_scan #(.CELL_PX(CELL_PX), .X_OFF(X_OFF), .GAP(0)) u_dut0 (
    .clk_40M(clk_40M), .rst(rst), .game_table_in(game_table_in),
    .frame_req(frame_req), .lcd_ready(lcd_ready), .lcd_valid(w_valid[0]),
    .lcd_cmd(w_cmd[0]), .lcd_data(w_data[0]), .busy(w_busy[0]),
    .frame_done(w_done[0]));

  game_table_lcd_scan #(.CELL_PX(CELL_PX), .X_OFF(X_OFF), .GAP(1)) u_dut1 (
    .clk_40M(clk_40M), .rst(rst), .game_table_in(game_table_in),
    .frame_req(frame_req), .lcd_ready(lcd_ready), .lcd_valid(w_valid[1]),
    .lcd_cmd(w_cmd[1]), .lcd_data(w_data[1]), .busy(w_busy[1]),
    .frame_done(w_done[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {cmd, data} for byte k of a frame, straight from the pixel rule.
  function automatic logic [8:0] model_byte(input logic [99:0] t, input int gap, input int k);
    int page, j, x, y;
    logic [7:0] b;
    page = k / BYTES_PER_PAGE;
    j    = k % BYTES_PER_PAGE;
    if (j == 0) return {1'b1, 8'hB8 | 8'(page)};
    if (j == 1) return {1'b1, 8'h40 | 8'(X_OFF)};
    x = j - 2;
    b = '0;
    for (int bit_i = 0; bit_i < 8; bit_i++) begin
      y = 8 * page + bit_i;
      if (y < 10 * CELL_PX) begin
        b[bit_i] = t[(y / CELL_PX) * 10 + x / CELL_PX];
        if (gap != 0 && ((x % CELL_PX == CELL_PX - 1) || (y % CELL_PX == CELL_PX - 1)))
          b[bit_i] = 1'b0;
      end
    end
    return {1'b0, b};
  endfunction

  task automatic mon(input int d);
    if (rst) begin
      idx[d] = 0; in_frame[d] = 1'b0; pv[d] = 1'b0;
      return;
    end
    if (w_busy[d] && !in_frame[d]) begin
      in_frame[d] = 1'b1;
      msnap[d]    = game_table_in;
      idx[d]      = 0;
    end
    if (pv[d] && !pr[d]) begin
      check($sformatf("stall_hold%0d", d), {w_valid[d], w_cmd[d], w_data[d]},
            {1'b1, pcmd[d], pdata[d]});
    end
    if (w_valid[d]) begin
      check($sformatf("valid_in_frame%0d", d), {31'd0, in_frame[d] && w_busy[d]}, 32'd1);
      check($sformatf("byte%0d_k%0d", d, idx[d]), {w_cmd[d], w_data[d]},
            model_byte(msnap[d], d, idx[d]));
      if (lcd_ready) idx[d]++;
    end
    if (w_done[d]) begin
      check($sformatf("frame_len%0d", d), idx[d], BYTES_PER_FRAME);
      in_frame[d] = 1'b0;
      frames[d]++;
    end
    pv[d] = w_valid[d]; pr[d] = lcd_ready; pcmd[d] = w_cmd[d]; pdata[d] = w_data[d];
  endtask

  // Compare process: both DUTs checked on every falling edge.
  always @(negedge clk_40M) begin
    mon(0);
    mon(1);
  end

  // Ready driver: always high unless random back-pressure is enabled.
  initial begin
    forever begin
      @(posedge clk_40M);
      #1 lcd_ready = rand_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  task automatic pulse_req();
    @(posedge clk_40M); #1 frame_req = 1'b1;
    @(posedge clk_40M); #1 frame_req = 1'b0;
  endtask

  // Run one frame and wait (bounded) for frame_done; optionally change the
  // live table mid-frame.
  task automatic do_frame(input int budget, input bit change, input logic [99:0] new_tbl);
    bit seen = 1'b0;
    pulse_req();
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk_40M);
      if (change && c == 40) game_table_in = new_tbl;
      if (w_done[0]) seen = 1'b1;
    end
    check("frame_complete", {31'd0, seen}, 32'd1);
  endtask

  // Measure latency of first byte and frame_done with ready held high.
  task automatic timed_frame(input string tag);
    int first_v = 0;
    int done_c  = 0;
    logic [8:0] first_b = '0;
    pulse_req();
    for (int c = 1; c <= 600 && done_c == 0; c++) begin
      @(negedge clk_40M);
      if (w_valid[0] && first_v == 0) begin
        first_v = c;
        first_b = {w_cmd[0], w_data[0]};
      end
      if (w_done[0]) done_c = c;
    end
    check({tag, "_first_valid_cycle"}, first_v, 2);
    check({tag, "_first_byte"}, {23'd0, first_b}, 32'h1B8);
    check({tag, "_done_cycle"}, done_c, 498);
  endtask

  initial begin
    logic [99:0] t;
    int f_before;
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; in_frame[d] = 0; frames[d] = 0; pv[d] = 0; pr[d] = 0;
      pcmd[d] = 0; pdata[d] = 0; msnap[d] = '0;
    end

    // Model pinned against hand-computed bytes
    t = 100'd1;
    check("model_cell0_x0", model_byte(t, 0, 2), 32'h03F);
    check("model_cell0_x5", model_byte(t, 0, 7), 32'h03F);
    check("model_cell0_x6", model_byte(t, 0, 8), 32'h000);
    check("model_gap_x0", model_byte(t, 1, 2), 32'h01F);
    check("model_gap_x5", model_byte(t, 1, 7), 32'h000);
    check("model_page0_cmd", model_byte(t, 0, 0), 32'h1B8);
    check("model_col_cmd", model_byte(t, 0, 1), 32'h142);
    check("model_page7_cmd", model_byte(t, 0, 7 * BYTES_PER_PAGE), 32'h1BF);
    t = '0; t[99] = 1'b1;
    check("model_c99_p6", model_byte(t, 0, 6 * BYTES_PER_PAGE + 2 + 54), 32'h0C0);
    check("model_c99_p7", model_byte(t, 0, 7 * BYTES_PER_PAGE + 2 + 59), 32'h00F);
    check("model_c99_p7_x53", model_byte(t, 0, 7 * BYTES_PER_PAGE + 2 + 53), 32'h000);

    // Reset state
    repeat (2) @(negedge clk_40M);
    check("rst_outputs0", {w_valid[0], w_cmd[0], w_data[0], w_busy[0], w_done[0]}, 32'h0);
    check("rst_outputs1", {w_valid[1], w_cmd[1], w_data[1], w_busy[1], w_done[1]}, 32'h0);
    @(posedge clk_40M); #1 rst = 1'b0;

    // Empty table, ready high: latency and frame length
    timed_frame("empty");

    // Single corner cells
    game_table_in = 100'd1;
    do_frame(700, 1'b0, '0);
    game_table_in = '0; game_table_in[99] = 1'b1;
    do_frame(700, 1'b0, '0);

    // Random tables, then random back-pressure with a mid-frame table change
    game_table_in = {$urandom(), $urandom(), $urandom(), 4'($urandom())};
    do_frame(700, 1'b0, '0);
    rand_en = 1'b1;
    game_table_in = {$urandom(), $urandom(), $urandom(), 4'($urandom())};
    do_frame(2500, 1'b1, ~game_table_in);
    rand_en = 1'b1;
    game_table_in = {$urandom(), $urandom(), $urandom(), 4'($urandom())};
    do_frame(2500, 1'b1, {$urandom(), $urandom(), $urandom(), 4'($urandom())});
    rand_en = 1'b0;

    // Two extra requests during a busy frame collapse into one extra frame
    repeat (3) @(posedge clk_40M);
    f_before = frames[0];
    pulse_req();
    repeat (10) @(posedge clk_40M);
    pulse_req();
    repeat (20) @(posedge clk_40M);
    pulse_req();
    repeat (1200) @(negedge clk_40M);
    check("collapsed_frames", frames[0] - f_before, 2);
    check("collapsed_idle", {31'd0, w_busy[0]}, 32'd0);

    // Reset and request together: request dropped
    @(posedge clk_40M); #1 rst = 1'b1; frame_req = 1'b1;
    @(posedge clk_40M); #1 rst = 1'b0; frame_req = 1'b0;
    repeat (4) @(negedge clk_40M);
    check("rst_req_dropped", {30'd0, w_busy}, 32'd0);

    // Reset mid-DATA aborts, next request restarts at page 0
    game_table_in = 100'd1;
    pulse_req();
    repeat (100) @(posedge clk_40M);
    #1 rst = 1'b1;
    @(negedge clk_40M);
    check("abort_valid", {30'd0, w_valid}, 32'd0);
    check("abort_busy", {30'd0, w_busy}, 32'd0);
    @(posedge clk_40M); #1 rst = 1'b0;
    repeat (3) @(posedge clk_40M);
    timed_frame("restart");

    repeat (5) @(posedge clk_40M);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
